// File: rtl/a51_sequencer.sv
// a51_sequencer: one FSM that loads, mixes and runs an A5/1 register core, packs keystream into bytes.
// Build option: define A51_SEQ_LSBFIRST_EN to pack each byte LSB first (default is MSB first).
module a51_sequencer #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int OUT_BITS   = 224
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  ks_bit,
    output logic                  lfsr_load,
    output logic                  load_bit,
    output logic                  lfsr_run,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [4:0]            byte_index,
    output logic                  busy,
    output logic                  done
);

    localparam logic [9:0] KEY_LAST   = 10'(KEY_BITS - 1);
    localparam logic [9:0] FRAME_LAST = 10'(FRAME_BITS - 1);
    localparam logic [9:0] MIX_LAST   = 10'(MIX_CYCLES - 1);
    localparam logic [9:0] OUT_LAST   = 10'(OUT_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_FRAME,
        S_MIX,
        S_OUT,
        S_DRAIN
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [9:0] stage_cnt;
    logic [2:0] pack_cnt;
    logic [7:0] pack;
    logic [7:0] pack_nx;
    logic       key_bit;
    logic       frame_bit;
    logic       stall;
    logic       capture;
    logic       byte_full;
    logic       xfer;

    assign xfer      = byte_valid & byte_ready;
    // Hold the generator only when the 8th bit would overwrite an unaccepted byte.
    assign stall     = (pack_cnt == 3'd7) & byte_valid & ~byte_ready;
    assign byte_full = capture & (pack_cnt == 3'd7);
    assign busy      = (state != S_IDLE);

`ifdef A51_SEQ_LSBFIRST_EN
    assign pack_nx = {ks_bit, pack[7:1]};
`else
    assign pack_nx = {pack[6:0], ks_bit};
`endif

    always_comb begin
        key_bit = 1'b0;
        for (int i = 0; i < KEY_BITS; i++) begin
            if (stage_cnt == 10'(i)) key_bit = key[i];
        end
    end

    always_comb begin
        frame_bit = 1'b0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (stage_cnt == 10'(i)) frame_bit = frame[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        lfsr_load = 1'b0;
        lfsr_run  = 1'b0;
        load_bit  = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_KEY;
            end
            S_KEY: begin
                lfsr_load = 1'b1;
                load_bit  = key_bit;
                if (stage_cnt == KEY_LAST) state_nx = S_FRAME;
            end
            S_FRAME: begin
                lfsr_load = 1'b1;
                load_bit  = frame_bit;
                if (stage_cnt == FRAME_LAST) state_nx = S_MIX;
            end
            S_MIX: begin
                lfsr_run = 1'b1;
                if (stage_cnt == MIX_LAST) state_nx = S_OUT;
            end
            S_OUT: begin
                lfsr_run = ~stall;
                capture  = ~stall;
                if (~stall && (stage_cnt == OUT_LAST)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (xfer) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_cnt  <= 10'd0;
            pack_cnt   <= 3'd0;
            pack       <= 8'd0;
            byte_data  <= 8'd0;
            byte_valid <= 1'b0;
            byte_index <= 5'd0;
            done       <= 1'b0;
        end else begin
            done <= (state == S_DRAIN) & xfer;

            // In OUT the stage counter counts captured bits, not cycles.
            if (state_nx != state)
                stage_cnt <= 10'd0;
            else if ((state == S_KEY) || (state == S_FRAME) || (state == S_MIX) || capture)
                stage_cnt <= stage_cnt + 10'd1;

            if ((state == S_IDLE) && start) begin
                pack_cnt   <= 3'd0;
                byte_index <= 5'd0;
            end else begin
                if (capture) begin
                    pack     <= pack_nx;
                    pack_cnt <= pack_cnt + 3'd1;
                end
                if (xfer) byte_index <= byte_index + 5'd1;
            end

            if (byte_full) begin
                byte_data  <= pack_nx;
                byte_valid <= 1'b1;
            end else if (xfer) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_a51_sequencer.sv
// Bench for a51_sequencer: behavioural A5/1 core on the DUT's control outputs plus a golden keystream model.
module tb_a51_sequencer;

    localparam int MAXC = 700;
    localparam logic [63:0] VKEY = 64'h1223456789ABCDEF;
    localparam logic [21:0] VFRM = 22'h134;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic [21:0] frame;
    logic        ks_bit;
    logic        lfsr_load;
    logic        load_bit;
    logic        lfsr_run;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [4:0]  byte_index;
    logic        busy;
    logic        done;

    a51_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .frame(frame),
        .ks_bit(ks_bit), .lfsr_load(lfsr_load), .load_bit(load_bit), .lfsr_run(lfsr_run),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_index(byte_index), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A5/1 register core driven by the sequencer
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic        dp_clr;
    logic        maj;
    assign ks_bit = r1[18] ^ r2[21] ^ r3[22];
    assign maj    = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);

    always @(posedge clk) begin
        if (dp_clr) begin
            r1 <= '0; r2 <= '0; r3 <= '0;
        end else if (lfsr_load) begin
            r1 <= {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ load_bit};
            r2 <= {r2[20:0], r2[21] ^ r2[20] ^ load_bit};
            r3 <= {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ load_bit};
        end else if (lfsr_run) begin
            if (r1[8] == maj)  r1 <= {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13]};
            if (r2[10] == maj) r2 <= {r2[20:0], r2[21] ^ r2[20]};
            if (r3[10] == maj) r3 <= {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7]};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Golden keystream: standard A5/1 key setup, 100 mix steps, then output bit taken before each step
    bit [7:0] gold [28];
    task automatic make_gold(input logic [63:0] k, input logic [21:0] f);
        bit [18:0] a; bit [21:0] b; bit [22:0] c; bit lb, m, o; bit [7:0] by;
        a = '0; b = '0; c = '0; by = '0;
        for (int i = 0; i < 86; i++) begin
            lb = (i < 64) ? k[i] : f[i-64];
            a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ lb};
            b = {b[20:0], b[21] ^ b[20] ^ lb};
            c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ lb};
        end
        for (int j = 0; j < 324; j++) begin
            if (j >= 100) begin
                o = a[18] ^ b[21] ^ c[22];
`ifdef A51_SEQ_LSBFIRST_EN
                by = {o, by[7:1]};
`else
                by = {by[6:0], o};
`endif
                if ((j - 100) % 8 == 7) gold[(j - 100) / 8] = by;
            end
            m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
            if (a[8] == m)  a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
            if (b[10] == m) b = {b[20:0], b[21] ^ b[20]};
            if (c[10] == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
        end
    endtask

    bit lg_load [0:MAXC];
    bit lg_run  [0:MAXC];
    bit lg_vld  [0:MAXC];
    bit lg_busy [0:MAXC];
    bit lg_done [0:MAXC];
    int lg_idx  [0:MAXC];
    bit [7:0] got [28];
    int first_v, done_c, n_load, n_lb1, lb_err, n_run, last_run_c, n_xfer, unstable, stall_low;

    // One run; cycle c is the c-th cycle after the edge that samples start
    task automatic run(input bit bp, input bit mid_start);
        bit hold; logic [7:0] hold_data; bit exp_lb;
        first_v = -1; done_c = -1; n_load = 0; n_lb1 = 0; lb_err = 0; n_run = 0;
        last_run_c = 0; n_xfer = 0; unstable = 0; stall_low = 0; hold = 0; hold_data = '0;
        for (int i = 0; i <= MAXC; i++) begin
            lg_load[i] = 0; lg_run[i] = 0; lg_vld[i] = 0; lg_busy[i] = 0; lg_done[i] = 0; lg_idx[i] = 0;
        end
        for (int i = 0; i < 28; i++) got[i] = '0;
        @(negedge clk); dp_clr = 1'b1; byte_ready = 1'b1;
        @(negedge clk); dp_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            if (byte_valid && first_v < 0) first_v = c;
            byte_ready = bp ? !(first_v >= 0 && c < first_v + 20) : 1'b1;
            start = mid_start && (c == 120);
            #1;
            lg_load[c] = lfsr_load; lg_run[c] = lfsr_run; lg_vld[c] = byte_valid;
            lg_busy[c] = busy; lg_done[c] = done; lg_idx[c] = int'(byte_index);
            if (lfsr_load) begin
                exp_lb = (n_load < 64) ? key[n_load] : frame[n_load - 64 < 22 ? n_load - 64 : 0];
                if (load_bit) n_lb1++;
                if (load_bit !== exp_lb) lb_err++;
                n_load++;
            end
            if (lfsr_run) begin n_run++; last_run_c = c; end
            if (hold && byte_valid && byte_data !== hold_data) unstable++;
            hold = byte_valid && !byte_ready;
            hold_data = byte_data;
            if (byte_valid && byte_ready) begin
                if (n_xfer < 28) got[n_xfer] = byte_data;
                n_xfer++;
            end
            if (done && done_c < 0) done_c = c;
            if (done_c > 0 && c >= done_c + 1) break;
        end
        start = 1'b0;
        for (int c = 187; c <= last_run_c; c++) if (!lg_run[c]) stall_low++;
    endtask

    typedef struct {
        int cyc; bit ld; bit rn; bit vl; bit bs; bit dn; int idx;
    } vec_t;
    vec_t tbl [14];

    initial begin
        int fv;
        tbl[0]  = '{1,   1, 0, 0, 1, 0, 0};
        tbl[1]  = '{64,  1, 0, 0, 1, 0, 0};
        tbl[2]  = '{65,  1, 0, 0, 1, 0, 0};
        tbl[3]  = '{86,  1, 0, 0, 1, 0, 0};
        tbl[4]  = '{87,  0, 1, 0, 1, 0, 0};
        tbl[5]  = '{186, 0, 1, 0, 1, 0, 0};
        tbl[6]  = '{187, 0, 1, 0, 1, 0, 0};
        tbl[7]  = '{194, 0, 1, 0, 1, 0, 0};
        tbl[8]  = '{195, 0, 1, 1, 1, 0, 0};
        tbl[9]  = '{196, 0, 1, 0, 1, 0, 1};
        tbl[10] = '{410, 0, 1, 0, 1, 0, 27};
        tbl[11] = '{411, 0, 0, 1, 1, 0, 27};
        tbl[12] = '{412, 0, 0, 0, 0, 1, 28};
        tbl[13] = '{413, 0, 0, 0, 0, 0, 28};

        reset = 1'b1; start = 1'b0; key = '0; frame = '0; byte_ready = 1'b1; dp_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.load", int'(lfsr_load), 0);
        chk("rst.run", int'(lfsr_run), 0);
        chk("rst.load_bit", int'(load_bit), 0);
        chk("rst.data", int'(byte_data), 0);
        chk("rst.valid", int'(byte_valid), 0);
        chk("rst.index", int'(byte_index), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        reset = 1'b0; dp_clr = 1'b0;

        // Zero key/frame, start pulsed again during MIX
        run(1'b0, 1'b1);
        foreach (tbl[i]) begin
            chk($sformatf("c%0d.load", tbl[i].cyc), int'(lg_load[tbl[i].cyc]), int'(tbl[i].ld));
            chk($sformatf("c%0d.run", tbl[i].cyc), int'(lg_run[tbl[i].cyc]), int'(tbl[i].rn));
            chk($sformatf("c%0d.valid", tbl[i].cyc), int'(lg_vld[tbl[i].cyc]), int'(tbl[i].vl));
            chk($sformatf("c%0d.busy", tbl[i].cyc), int'(lg_busy[tbl[i].cyc]), int'(tbl[i].bs));
            chk($sformatf("c%0d.done", tbl[i].cyc), int'(lg_done[tbl[i].cyc]), int'(tbl[i].dn));
            chk($sformatf("c%0d.index", tbl[i].cyc), lg_idx[tbl[i].cyc], tbl[i].idx);
        end
        chk("zero.load_cycles", n_load, 86);
        chk("zero.load_bit_ones", n_lb1, 0);
        chk("zero.run_cycles", n_run, 324);
        chk("zero.transfers", n_xfer, 28);
        chk("zero.done_cycle", done_c, 412);

        // Vector run, consumer always ready
        key = VKEY; frame = VFRM;
        make_gold(VKEY, VFRM);
        run(1'b0, 1'b0);
        for (int i = 0; i < 28; i++) chk($sformatf("vec.byte%0d", i), int'(got[i]), int'(gold[i]));
        chk("vec.transfers", n_xfer, 28);
        chk("vec.load_bit_errs", lb_err, 0);
        chk("vec.final_index", int'(byte_index), 28);
        chk("vec.done_cycle", done_c, 412);

        // Vector run with 20 cycles of backpressure from the first valid byte
        run(1'b1, 1'b0);
        for (int i = 0; i < 28; i++) chk($sformatf("bp.byte%0d", i), int'(got[i]), int'(gold[i]));
        chk("bp.first_valid", first_v, 195);
        chk("bp.stall_cycles", stall_low, 13);
        chk("bp.run_cycles", n_run, 324);
        chk("bp.unstable", unstable, 0);
        chk("bp.done_cycle", done_c, 425);

        // Reset for two cycles mid-OUT, with start held during the second
        @(negedge clk); dp_clr = 1'b1; byte_ready = 1'b1;
        @(negedge clk); dp_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (250) @(negedge clk);
        chk("mid.busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); #1;
        chk("mid.load", int'(lfsr_load), 0);
        chk("mid.run", int'(lfsr_run), 0);
        chk("mid.data", int'(byte_data), 0);
        chk("mid.valid", int'(byte_valid), 0);
        chk("mid.index", int'(byte_index), 0);
        chk("mid.busy", int'(busy), 0);
        chk("mid.done", int'(done), 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        fv = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (byte_valid) begin fv = c; break; end
        end
        chk("mid.restart_first_valid", fv, 195);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a51_sequencer.md
# a51_sequencer

Control sequencer for the A5/1 keystream generator: it replaces the free-running stage counter and edge-detect glue with one FSM.
- Drives the three-register A5/1 datapath: load-enable, run-enable and the serial key/frame load bit.
- Collects the keystream bits the datapath returns and packs them into bytes.
- Hands bytes to the XOR/LCD path over a valid/ready handshake, stalling the generator under backpressure.
- Sits between the key/frame store registers and the A5/1 register core.

## Interface
Parameters:
- KEY_BITS, 64, key bits shifted in during KEY stage
- FRAME_BITS, 22, frame-number bits shifted in during FRAME stage
- MIX_CYCLES, 100, majority-clocked discard cycles
- OUT_BITS, 224, keystream bits produced; must be a multiple of 8

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  request a keystream run; honoured only in IDLE
- key  in  KEY_BITS  session key, shifted LSB first
- frame  in  FRAME_BITS  frame number, shifted LSB first
- ks_bit  in  1  combinational A5/1 output bit (XOR of the three register MSBs)
- lfsr_load  out  1  clock all three registers, feedback XOR load_bit
- load_bit  out  1  serial key/frame bit
- lfsr_run  out  1  majority-clocked step enable
- byte_data  out  8  packed keystream byte
- byte_valid  out  1  byte_data holds an unconsumed byte
- byte_ready  in  1  consumer accepts byte this cycle
- byte_index  out  5  count of bytes accepted this run
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final byte accepted

## Operation
States and transitions:
- IDLE → KEY on start.
- KEY: KEY_BITS cycles, then FRAME.
- FRAME: FRAME_BITS cycles, then MIX.
- MIX: MIX_CYCLES cycles, then OUT.
- OUT: until OUT_BITS bits captured, then DRAIN.
- DRAIN: until the last byte is accepted, then IDLE with done pulse.

Stage outputs:
- KEY/FRAME: lfsr_load=1, lfsr_run=0. In stage cycle i, load_bit = key[i] (KEY) or frame[i] (FRAME).
- Outside KEY/FRAME: load_bit=0.
- MIX: lfsr_run=1.
- OUT: lfsr_run = ~stall.

Stall and capture:
- stall = (pack_cnt==7) & byte_valid & ~byte_ready. This is a combinational path from byte_ready.
- Each OUT cycle with lfsr_run=1 captures ks_bit (the pre-step value) into the pack register.
- Capture order is MSB first: the first bit of each byte goes to bit 7.
- On the 8th capture the completed byte loads the hold register; byte_valid is set next cycle.

Handshake:
- Transfer occurs on byte_valid & byte_ready.
- byte_data is stable while byte_valid=1 and byte_ready=0.
- byte_valid clears the cycle after a transfer unless a new byte loads in the same cycle.
- byte_index increments per transfer and resets to 0 on start acceptance.

Other rules:
- A single 10-bit stage counter is reused and cleared at each stage change.
- start while busy is ignored; start in the same cycle as reset is ignored.
- The key and frame inputs must stay stable from start through the end of FRAME. The block does not latch them.

## Timing
Reset values:
- State=IDLE.
- lfsr_load=0, lfsr_run=0, load_bit=0.
- byte_data=0, byte_valid=0, byte_index=0.
- busy=0, done=0.
- All counters 0.

Run timeline (start sampled at cycle 0, byte_ready held 1):
- KEY cycles 1–64.
- FRAME cycles 65–86.
- MIX cycles 87–186.
- OUT captures at cycles 187–410.
- First byte_valid at cycle 195.
- Last byte accepted at cycle 411; done=1 and busy=0 at cycle 412.

Stall and reset behaviour:
- Each stall cycle delays all later events by one cycle; no bits are lost or duplicated.
- Reset mid-run: the next cycle is IDLE with all outputs at reset values. The partially loaded registers are not cleared by this block; the next start fully reloads them.

## Configuration
- A51_SEQ_LSBFIRST_EN defined: each packed byte is LSB first, i.e. the first captured bit goes to byte_data[0].
- A51_SEQ_LSBFIRST_EN undefined: bytes are MSB first (default).
- Timing and handshake are identical in both builds.

## Test plan
- Reset: assert reset 2 cycles mid-OUT → next cycle all outputs 0, busy=0; start then gives first byte_valid exactly 195 cycles later.
- Stage counts: key=0, frame=0, byte_ready=1 → 64 lfsr_load cycles (load_bit=0), 22 lfsr_load cycles, 100 lfsr_run cycles, 224 captures, 28 transfers, done at cycle 412.
- Vector: key=64'h1223456789ABCDEF, frame=22'h134, bench golden A5/1 model → 28 bytes match the model exactly; byte_index reaches 28.
- Backpressure: same vector, byte_ready=0 for 20 cycles starting when first byte_valid rises → lfsr_run low 13 cycles while the 8th bit of byte 2 waits; the byte stream equals the vector test; done at cycle 425.
- Ignored start: pulse start during MIX → no state change, timeline unchanged.
- Macro build: A51_SEQ_LSBFIRST_EN defined, vector test → every byte is the bit-reverse of the default-build byte.
